// File: rtl/divider_unit.sv
// divider_unit: sequential 32-bit unsigned restoring divider.
//
// Each release of the active-low reset starts one division. The first
// rising edge after release loads the operands (LOAD), the next 32 edges
// each develop one quotient bit (RUN), and the unit then parks in DONE
// with all registers frozen until the next reset.
//
// Ports:
//   clk       in   1  rising-edge clock
//   quotient  out 32  final quotient, 0 until finished
//   remainder out 64  working register; in DONE [63:32]=remainder,
//                     [31:0]=quotient
//   finished  out  1  result valid, held until the next reset
//   dvdend    in  32  unsigned dividend, sampled on the LOAD edge only
//   dvsor     in  32  unsigned divisor, sampled on the LOAD edge only
//   reset     in   1  asynchronous, active-low clear; release starts a division
//
// Handshake: there is no ready/valid pair. The controller holds operands
// across the LOAD edge and treats finished as the only valid qualifier;
// quotient, remainder and finished become valid on the same edge
// (the 33rd edge after reset release) and stay put until reset drops.
//
// The FSM state is kept in the named register `state` (type state_t) so a
// checker can bind to it directly.

module divider_unit (
  input  logic        clk,
  output logic [31:0] quotient,
  output logic [63:0] remainder,
  output logic        finished,
  input  logic [31:0] dvdend,
  input  logic [31:0] dvsor,
  input  logic        reset
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [4:0]  count, count_n;
  logic [63:0] rem_q, rem_n;
  logic [31:0] quo_q, quo_n;
  logic        fin_q, fin_n;
  logic [31:0] div_q, div_n;

  // Upper part of the remainder register after a one-bit left shift.
  // It is 33 bits wide so the bit shifted out of [63] takes part in the
  // compare; without it, divisors >= 2^31 produce wrong quotient bits.
  logic [32:0] upper;
  logic [31:0] diff;

  assign upper = rem_q[63:31];
  // Only the low 32 bits of the difference are kept: whenever the
  // subtraction is taken, the true difference is below 2^32.
  assign diff  = upper[31:0] - div_q;

  always_comb begin
    state_n = state;
    count_n = count;
    rem_n   = rem_q;
    quo_n   = quo_q;
    fin_n   = fin_q;
    div_n   = div_q;
    case (state)
      LOAD: begin
        rem_n   = {32'b0, dvdend};
        div_n   = dvsor;
        count_n = 5'd0;
        state_n = RUN;
      end
      RUN: begin
        if (upper >= {1'b0, div_q}) begin
          rem_n = {diff, rem_q[30:0], 1'b1};
        end else begin
          rem_n = {rem_q[62:0], 1'b0};
        end
        count_n = count + 5'd1;
        if (count == 5'd31) begin
          quo_n   = rem_n[31:0];
          fin_n   = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        // Everything holds until the next reset.
      end
      default: begin
        state_n = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
      count <= 5'd0;
      rem_q <= 64'd0;
      quo_q <= 32'd0;
      fin_q <= 1'b0;
      div_q <= 32'd0;
    end else begin
      state <= state_n;
      count <= count_n;
      rem_q <= rem_n;
      quo_q <= quo_n;
      fin_q <= fin_n;
      div_q <= div_n;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign finished  = fin_q;

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: self-checking bench for divider_unit.
// Directed vectors from a table, hand-written abort / operand-change /
// hold sequences, and random operands checked against plain / and %.

module tb_divider_unit;

  localparam int W = 64;

  logic        clk;
  logic        reset;
  logic [31:0] dvdend;
  logic [31:0] dvsor;
  logic [31:0] quotient;
  logic [63:0] remainder;
  logic        finished;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  divider_unit dut (
    .clk       (clk),
    .quotient  (quotient),
    .remainder (remainder),
    .finished  (finished),
    .dvdend    (dvdend),
    .dvsor     (dvsor),
    .reset     (reset)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Returns {quotient, remainder}; divide by zero yields all-ones / dividend.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulse reset with new operands, release on a falling edge, then count
  // rising edges until finished. Optionally changes dvdend after chg_edge
  // edges (0 = never) to show operands are not re-sampled.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int chg_edge, input logic [31:0] chg_val);
    int edges;
    bit done;
    @(negedge clk);
    reset  = 1'b0;
    dvdend = a;
    dvsor  = b;
    #1;
    check({name, "_fin_in_reset"}, {63'd0, finished}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == chg_edge) dvdend = chg_val;
      if (finished) done = 1'b1;
    end
    check({name, "_latency"}, 64'(edges), 64'd33);
    check({name, "_quotient"}, {32'd0, quotient}, {32'd0, exp[63:32]});
    check({name, "_rem_hi"}, {32'd0, remainder[63:32]}, {32'd0, exp[31:0]});
    check({name, "_rem_lo"}, {32'd0, remainder[31:0]}, {32'd0, exp[63:32]});
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] held_rem;
    logic [31:0] held_quo;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] e;

    vecs[0] = '{"v7_2",      32'd7,          32'd2,          32'd3,          32'd1};
    vecs[1] = '{"v100_7",    32'd100,        32'd7,          32'd14,         32'd2};
    vecs[2] = '{"v3_10",     32'd3,          32'd10,         32'd0,          32'd3};
    vecs[3] = '{"vmax_1",    32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[4] = '{"vmax_msb",  32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF};
    vecs[5] = '{"vdiv0",     32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234};

    // Reset state.
    reset  = 1'b0;
    dvdend = 32'd0;
    dvsor  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_quotient", {32'd0, quotient}, 64'd0);
    check("reset_remainder", remainder, 64'd0);
    check("reset_finished", {63'd0, finished}, 64'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_div(vecs[i].name, vecs[i].a, vecs[i].b, {vecs[i].q, vecs[i].r}, 0, 32'd0);
    end

    // Result holds in DONE while operands wander.
    run_div("hold", 32'd7, 32'd2, {32'd3, 32'd1}, 0, 32'd0);
    held_rem = remainder;
    held_quo = quotient;
    dvdend = 32'd999;
    dvsor  = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("hold_finished", {63'd0, finished}, 64'd1);
    check("hold_remainder", remainder, held_rem);
    check("hold_quotient", {32'd0, quotient}, {32'd0, held_quo});

    // Abort after 10 RUN edges: outputs clear without waiting for a clock.
    @(negedge clk);
    reset  = 1'b0;
    dvdend = 32'd1000;
    dvsor  = 32'd3;
    @(negedge clk);
    reset = 1'b1;
    repeat (11) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("abort_quotient", {32'd0, quotient}, 64'd0);
    check("abort_remainder", remainder, 64'd0);
    check("abort_finished", {63'd0, finished}, 64'd0);
    run_div("after_abort", 32'd9, 32'd4, {32'd2, 32'd1}, 0, 32'd0);

    // Operand change during RUN is ignored.
    run_div("op_change", 32'd7, 32'd2, {32'd3, 32'd1}, 5, 32'd50);

    // Random operands against the model, via the expected queue.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = $urandom | 32'h8000_0000;
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      exp_q.push_back(model(ra, rb));
      e = exp_q.pop_front();
      run_div("rand", ra, rb, e, 0, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
